// File: rtl/cmos_dvp_pkg.sv
// Shared types and defaults for the DVP camera-port transmitter.
// Holds the state encoding, blanking defaults and blank-timer sizing.
package cmos_dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_LINE,
    ST_HBLANK,
    ST_VFP
  } state_t;

  localparam int unsigned DEF_VSYNC_CYCLES  = 16;
  localparam int unsigned DEF_VBP_CYCLES    = 32;
  localparam int unsigned DEF_HBLANK_CYCLES = 64;
  localparam int unsigned DEF_VFP_CYCLES    = 32;

  // Wide enough to hold the largest blanking interval, with one spare bit.
  function automatic int unsigned blank_timer_width(input int unsigned a, input int unsigned b,
                                                    input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/cmos_dvp_timer.sv
// Loadable down-counter shared by the VSYNC, VBP, HBLANK and VFP intervals.
// Load with (length-1); done is high on the last clock of the interval.
module cmos_dvp_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/cmos_dvp_tx.sv
// DVP camera-port transmitter: replays an AXI4-Stream frame as registered
// cmos_vsync / cmos_href / cmos_data with programmable blanking.
module cmos_dvp_tx
  import cmos_dvp_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH    = 8,
  parameter int unsigned C_IMG_WBITS     = 12,
  parameter int unsigned C_IMG_HBITS     = 12,
  parameter int unsigned C_VSYNC_CYCLES  = DEF_VSYNC_CYCLES,
  parameter int unsigned C_VBP_CYCLES    = DEF_VBP_CYCLES,
  parameter int unsigned C_HBLANK_CYCLES = DEF_HBLANK_CYCLES,
  parameter int unsigned C_VFP_CYCLES    = DEF_VFP_CYCLES
) (
  input  logic                    cmos_pclk,
  input  logic                    resetn,
  input  logic [C_IMG_WBITS-1:0]  img_width,
  input  logic [C_IMG_HBITS-1:0]  img_height,
  input  logic                    s_axis_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    cmos_vsync,
  output logic                    cmos_href,
  output logic [C_DATA_WIDTH-1:0] cmos_data,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_underflow,
  output logic                    err_framing
);

  localparam int unsigned TW = blank_timer_width(C_VSYNC_CYCLES, C_VBP_CYCLES,
                                                 C_HBLANK_CYCLES, C_VFP_CYCLES);
  localparam logic [TW-1:0] VSYNC_LOAD  = TW'(C_VSYNC_CYCLES - 1);
  localparam logic [TW-1:0] VBP_LOAD    = TW'(C_VBP_CYCLES - 1);
  localparam logic [TW-1:0] HBLANK_LOAD = TW'(C_HBLANK_CYCLES - 1);
  localparam logic [TW-1:0] VFP_LOAD    = TW'(C_VFP_CYCLES - 1);

  state_t                  state, state_next;
  logic                    active;
  logic [C_IMG_WBITS-1:0]  w_last, pix;
  logic [C_IMG_HBITS-1:0]  h_last, line;
  logic                    timer_load, timer_done;
  logic [TW-1:0]           timer_value;
  logic                    last_pix, last_line, sof_ok, beat_bad;

  assign last_pix  = (pix == w_last);
  assign last_line = (line == h_last);
  assign sof_ok    = active && s_axis_tvalid && s_axis_tuser &&
                     (img_width != '0) && (img_height != '0);
  assign busy      = (state != ST_IDLE);
  // Only line 0 pixel 0 may carry tuser; tlast must mark exactly the last pixel.
  assign beat_bad  = (s_axis_tlast != last_pix) ||
                     (s_axis_tuser && !((line == '0) && (pix == '0)));

  cmos_dvp_timer #(.WIDTH(TW)) u_timer (
    .clk   (cmos_pclk),
    .rst_n (resetn),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  always_ff @(posedge cmos_pclk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    timer_load    = 1'b0;
    timer_value   = '0;
    s_axis_tready = 1'b0;
    unique case (state)
      ST_IDLE: begin
        s_axis_tready = active && !s_axis_tuser;
        if (sof_ok) begin
          state_next  = ST_VSYNC;
          timer_load  = 1'b1;
          timer_value = VSYNC_LOAD;
        end
      end
      ST_VSYNC: if (timer_done) begin
        state_next  = ST_VBP;
        timer_load  = 1'b1;
        timer_value = VBP_LOAD;
      end
      ST_VBP: if (timer_done) state_next = ST_LINE;
      ST_LINE: begin
        s_axis_tready = 1'b1;
        if (last_pix) begin
          state_next  = ST_HBLANK;
          timer_load  = 1'b1;
          timer_value = HBLANK_LOAD;
        end
      end
      ST_HBLANK: if (timer_done) begin
        if (last_line) begin
          state_next  = ST_VFP;
          timer_load  = 1'b1;
          timer_value = VFP_LOAD;
        end else begin
          state_next = ST_LINE;
        end
      end
      ST_VFP: if (timer_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Geometry is latched as terminal counts so mid-frame input changes are ignored.
  always_ff @(posedge cmos_pclk or negedge resetn) begin
    if (!resetn) begin
      w_last <= '0;
      h_last <= '0;
      pix    <= '0;
      line   <= '0;
    end else begin
      if (state == ST_IDLE && sof_ok) begin
        w_last <= img_width - C_IMG_WBITS'(1);
        h_last <= img_height - C_IMG_HBITS'(1);
        pix    <= '0;
        line   <= '0;
      end
      if (state == ST_LINE) pix <= last_pix ? '0 : pix + C_IMG_WBITS'(1);
      if (state == ST_HBLANK && timer_done && !last_line) line <= line + C_IMG_HBITS'(1);
    end
  end

  always_ff @(posedge cmos_pclk or negedge resetn) begin
    if (!resetn) begin
      active        <= 1'b0;
      cmos_vsync    <= 1'b0;
      cmos_href     <= 1'b0;
      cmos_data     <= '0;
      frame_done    <= 1'b0;
      err_underflow <= 1'b0;
      err_framing   <= 1'b0;
    end else begin
      active     <= 1'b1;
      cmos_vsync <= (state == ST_VSYNC);
      cmos_href  <= (state == ST_LINE);
      cmos_data  <= (state == ST_LINE && s_axis_tvalid) ? s_axis_tdata : '0;
      frame_done <= (state == ST_VFP) && timer_done;
      // DVP cannot stall: a missing beat still consumes its pixel slot.
      if (state == ST_LINE && !s_axis_tvalid) err_underflow <= 1'b1;
      if (state == ST_LINE && s_axis_tvalid && beat_bad) err_framing <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Self-checking bench for cmos_dvp_tx: directed scenarios plus randomized
// frames, compared cycle by cycle against a frame-level reference model.
module tb_cmos_dvp_tx;

  localparam int V   = 2;
  localparam int VBP = 3;
  localparam int HBL = 5;
  localparam int VFP = 4;

  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] img_width = 12'd4;
  logic [11:0] img_height = 12'd2;
  logic        tvalid, tuser, tlast, tready;
  logic [7:0]  tdata;
  logic        vsync, href, busy, frame_done, err_uf, err_fr;
  logic [7:0]  data;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t drv_q[$];
  beat_t plan[$];
  bit    gap[0:255];

  always #5 clk = ~clk;

  cmos_dvp_tx #(
    .C_DATA_WIDTH(8), .C_IMG_WBITS(12), .C_IMG_HBITS(12),
    .C_VSYNC_CYCLES(V), .C_VBP_CYCLES(VBP), .C_HBLANK_CYCLES(HBL), .C_VFP_CYCLES(VFP)
  ) dut (
    .cmos_pclk(clk), .resetn(resetn),
    .img_width(img_width), .img_height(img_height),
    .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tlast(tlast), .s_axis_tready(tready),
    .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
    .busy(busy), .frame_done(frame_done),
    .err_underflow(err_uf), .err_framing(err_fr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream driver: presents the queue head, drops tvalid on planned gap slots,
  // pops a beat once the handshake of the previous cycle is known.
  initial begin : driver
    bit    acc_pend, slot_pend;
    int    slot_idx;
    beat_t b;
    acc_pend = 0; slot_pend = 0; slot_idx = 0;
    tvalid = 0; tdata = '0; tuser = 0; tlast = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        acc_pend = 0; slot_pend = 0; slot_idx = 0;
      end else begin
        if (acc_pend && drv_q.size() > 0) void'(drv_q.pop_front());
        if (slot_pend) slot_idx++;
        if (!busy) slot_idx = 0;
      end
      if (resetn && drv_q.size() > 0) begin
        b = drv_q[0];
        tvalid = 1; tdata = b.data; tuser = b.user; tlast = b.last;
      end else begin
        tvalid = 0; tdata = '0; tuser = 0; tlast = 0;
      end
      if (busy && tready && slot_idx < 256 && gap[slot_idx]) tvalid = 0;
      #1;
      acc_pend  = tvalid && tready && resetn;
      slot_pend = busy && tready && resetn;
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic u, input logic l);
    beat_t b;
    b.data = d; b.user = u; b.last = l;
    plan.push_back(b);
    drv_q.push_back(b);
  endtask

  task automatic push_frame(input int w, input int h, input logic [7:0] base,
                            input bit rnd, input int bad_last_k);
    logic [7:0] d;
    logic       l;
    for (int k = 0; k < w * h; k++) begin
      d = rnd ? 8'($urandom) : base + 8'(k);
      l = ((k % w) == w - 1);
      if (k == bad_last_k) l = ~l;
      if (rnd && $urandom_range(9) == 0) l = ~l;
      push_beat(d, (k == 0), l);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 0;
    drv_q.delete();
    plan.delete();
    for (int i = 0; i < 256; i++) gap[i] = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
  endtask

  // Reference model: pixel slot k of the frame carries the next SOF-onward beat
  // unless it is a gap; output trace is laid out from the blanking arithmetic.
  task automatic run_frame(input int w, input int h, input string name);
    beat_t      mq[$];
    beat_t      b;
    logic [7:0] ep[0:255];
    bit         exp_uf, exp_fr;
    int         tot, n, u, ln, p;
    logic       e_vs, e_hr, e_fd;
    logic [7:0] e_d;
    mq = plan;
    exp_uf = 0; exp_fr = 0;
    while (mq.size() > 0 && !mq[0].user) void'(mq.pop_front());
    for (int k = 0; k < w * h; k++) begin
      if (gap[k] || mq.size() == 0) begin
        ep[k] = '0; exp_uf = 1;
      end else begin
        b = mq.pop_front();
        ep[k] = b.data;
        if (b.last != ((k % w) == w - 1)) exp_fr = 1;
        if (b.user && k != 0) exp_fr = 1;
      end
    end
    tot = V + VBP + h * (w + HBL) + VFP;
    n = 0;
    do begin @(negedge clk); n++; end while (!vsync && n < 400);
    check({name, " vsync_start"}, 32'(vsync), 32'd1);
    check({name, " busy_in_frame"}, 32'(busy), 32'd1);
    for (int t = 0; t <= tot; t++) begin
      if (t > 0) @(negedge clk);
      e_vs = (t < V);
      u = t - V - VBP;
      e_hr = 0; e_d = '0;
      if (u >= 0 && u < h * (w + HBL)) begin
        ln = u / (w + HBL);
        p  = u % (w + HBL);
        if (p < w) begin e_hr = 1; e_d = ep[ln * w + p]; end
      end
      e_fd = (t == tot - 1);
      check($sformatf("%s trace t=%0d {vs,href,fd,data}", name, t),
            32'({vsync, href, frame_done, data}), 32'({e_vs, e_hr, e_fd, e_d}));
      if (t == tot - 1) check({name, " busy_at_done"}, 32'(busy), 32'd0);
    end
    check({name, " err_underflow"}, 32'(err_uf), 32'(exp_uf));
    check({name, " err_framing"}, 32'(err_fr), 32'(exp_fr));
  endtask

  initial begin : main
    int w, h, t0;
    // Reset state
    #3;
    check("reset outputs {vs,href,data,fd}", 32'({vsync, href, data, frame_done}), 32'd0);
    check("reset tready", 32'(tready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset errors", 32'({err_uf, err_fr}), 32'd0);

    // Nominal frame
    do_reset();
    img_width = 12'd4; img_height = 12'd2;
    push_frame(4, 2, 8'h10, 0, -1);
    run_frame(4, 2, "nominal");

    // Underflow on pixel 2 of line 0
    do_reset();
    gap[2] = 1;
    push_frame(4, 2, 8'h10, 0, -1);
    run_frame(4, 2, "underflow");

    // Extra tlast on pixel 1
    do_reset();
    push_frame(4, 2, 8'h20, 0, 1);
    run_frame(4, 2, "framing");

    // Resync: three non-SOF beats precede SOF
    do_reset();
    push_beat(8'hA0, 0, 0);
    push_beat(8'hA1, 0, 1);
    push_beat(8'hA2, 0, 0);
    push_frame(4, 2, 8'h30, 0, -1);
    run_frame(4, 2, "resync");

    // Reset during line 1 pixel 2
    do_reset();
    push_frame(4, 2, 8'h40, 0, -1);
    t0 = 0;
    do begin @(negedge clk); t0++; end while (!vsync && t0 < 400);
    repeat (V + VBP + (4 + HBL) + 2) @(negedge clk);
    check("midreset pre {href,data}", 32'({href, data}), 32'({1'b1, 8'h46}));
    #2 resetn = 0;
    #1;
    check("midreset async {vs,href,data,busy}", 32'({vsync, href, data, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    drv_q.delete(); plan.delete();
    resetn = 1;
    push_frame(4, 2, 8'h50, 0, -1);
    run_frame(4, 2, "after_reset");

    // Zero width: SOF held, no frame
    do_reset();
    img_width = 12'd0; img_height = 12'd2;
    push_frame(4, 2, 8'h60, 0, -1);
    repeat (8) @(negedge clk);
    #2;
    check("zero_geom busy", 32'(busy), 32'd0);
    check("zero_geom tready", 32'(tready), 32'd0);
    check("zero_geom vsync", 32'(vsync), 32'd0);
    check("zero_geom beats_held", 32'(drv_q.size()), 32'd8);
    img_width = 12'd4;
    run_frame(4, 2, "zero_then_valid");

    // Randomized frames
    for (int r = 0; r < 4; r++) begin
      do_reset();
      w = $urandom_range(6, 1);
      h = $urandom_range(3, 1);
      img_width = 12'(w); img_height = 12'(h);
      for (int k = 1; k < w * h; k++) gap[k] = ($urandom_range(7) == 0);
      push_frame(w, h, 8'h00, 1, -1);
      run_frame(w, h, $sformatf("random%0d w=%0d h=%0d", r, w, h));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
